spatz_vrf_wbuf: RTL

Write-back buffer that sits directly upstream of one VRF write port. It accepts element writes from a functional unit or load unit over a valid/ready handshake and holds them in a small in-order FIFO. It drives the VRF write port (we/waddr/wdata/wbe) from the FIFO head, and coalesces back-to-back partial writes to the same element. It also exposes a pending-write address check so the issue logic can stall reads on read-after-write hazards.

---
 rtl/spatz_vrf_wbuf.sv | 105 ++++++++++
 1 files changed

// File: rtl/spatz_vrf_wbuf.sv
// Write-back buffer in front of one VRF write port: in-order FIFO that merges
// back-to-back partial writes to the same element and flags pending-write hazards.
module spatz_vrf_wbuf #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 64,
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8,
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ADDR_WIDTH-1:0] in_addr_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [BE_WIDTH-1:0]   in_be_i,
    output logic                  vrf_we_o,
    output logic [ADDR_WIDTH-1:0] vrf_waddr_o,
    output logic [DATA_WIDTH-1:0] vrf_wdata_o,
    output logic [BE_WIDTH-1:0]   vrf_wbe_o,
    input  logic                  vrf_wvalid_i,
    input  logic [ADDR_WIDTH-1:0] chk_addr_i,
    output logic                  chk_hit_o,
    output logic [PTR_WIDTH:0]    level_o,
    output logic                  empty_o
);

    localparam logic [PTR_WIDTH:0]   PTR_ONE  = 1;
    localparam logic [PTR_WIDTH-1:0] IDX_ONE  = 1;
    localparam logic [PTR_WIDTH:0]   FULL_LVL = DEPTH[PTR_WIDTH:0];

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [BE_WIDTH-1:0]   be_q   [DEPTH];
    logic [DEPTH-1:0]      valid_q;

    logic [PTR_WIDTH:0]   head_q, tail_q;
    logic [PTR_WIDTH-1:0] head_idx, tail_idx, last_idx;
    logic                 full, push, pop, merge, alloc;

    assign head_idx = head_q[PTR_WIDTH-1:0];
    assign tail_idx = tail_q[PTR_WIDTH-1:0];
    assign last_idx = tail_idx - IDX_ONE;

    // Pointer difference with wrap bit gives occupancy 0..DEPTH.
    assign level_o    = tail_q - head_q;
    assign empty_o    = (level_o == '0);
    assign full       = (level_o == FULL_LVL);
    assign in_ready_o = !full;

    assign push = in_valid_i && in_ready_o;
    assign pop  = vrf_we_o && vrf_wvalid_i;

    // Merging into the head while it drains would lose the new bytes.
    assign merge = push && valid_q[last_idx] && (addr_q[last_idx] == in_addr_i)
                   && !(pop && (last_idx == head_idx));
    assign alloc = push && !merge;

    assign vrf_we_o    = valid_q[head_idx];
    assign vrf_waddr_o = vrf_we_o ? addr_q[head_idx] : '0;
    assign vrf_wdata_o = vrf_we_o ? data_q[head_idx] : '0;
    assign vrf_wbe_o   = vrf_we_o ? be_q[head_idx]   : '0;

    always_comb begin
        chk_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == chk_addr_i)) chk_hit_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                be_q[i]   <= '0;
            end
        end else begin
            if (pop) begin
                valid_q[head_idx] <= 1'b0;
                head_q            <= head_q + PTR_ONE;
            end
            if (alloc) begin
                valid_q[tail_idx] <= 1'b1;
                addr_q[tail_idx]  <= in_addr_i;
                data_q[tail_idx]  <= in_data_i;
                be_q[tail_idx]    <= in_be_i;
                tail_q            <= tail_q + PTR_ONE;
            end else if (merge) begin
                for (int b = 0; b < BE_WIDTH; b++) begin
                    if (in_be_i[b]) data_q[last_idx][8*b +: 8] <= in_data_i[8*b +: 8];
                end
                be_q[last_idx] <= be_q[last_idx] | in_be_i;
            end
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
    a_wvalid_we:    assert property (@(posedge clk_i) disable iff (rst_i) vrf_wvalid_i |-> vrf_we_o);
    a_be_nonzero:   assert property (@(posedge clk_i) disable iff (rst_i) push |-> (in_be_i != '0));

endmodule
